// File: rtl/instr_fetch.sv
// Dual-issue instruction fetch: request FSM to the local store, pair queue, IF/ID presentation.
// Optional IF_ALIGN_EN: odd-word redirects deliver the first pair with a nop in the even slot.
module instr_fetch #(
  parameter int                ADDR_W   = 18,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                QDEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ls_req,
  output logic [ADDR_W-1:0] ls_addr,
  input  logic              ls_gnt,
  input  logic              ls_rvalid,
  input  logic [63:0]       ls_rdata,
  output logic [31:0]       instruction1_IF,
  output logic [31:0]       instruction2_IF,
  output logic              fetch_valid,
  output logic [ADDR_W-1:0] pc_IF
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(QDEPTH);
  localparam logic [31:0] SPU_NOP = 32'h40200000;

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] req_pc_reg, req_pc_next;
  logic [ADDR_W-1:0] last_pc_reg;
  logic              squash_reg, squash_next;
  logic [PTR_W-1:0]  rd_ptr_reg, wr_ptr_reg;
  logic [PTR_W:0]    count_reg, count_next;
  logic              push, pop, nonempty;
  logic [31:0]       push_even;
  logic              unused_bits;

  logic [31:0]       even_mem [QDEPTH];
  logic [31:0]       odd_mem  [QDEPTH];
  logic [ADDR_W-1:0] pc_mem   [QDEPTH];

  assign nonempty = (count_reg != '0);
  assign unused_bits = ^redirect_pc[2:0];

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    req_pc_next = req_pc_reg;
    squash_next = squash_reg;
    push        = 1'b0;
    pop         = nonempty && !stall && !flush;

    case (state_reg)
      S_FETCH: begin
        if (ls_gnt) begin
          pc_next     = pc_reg + ADDR_W'(8);
          req_pc_next = pc_reg;
          state_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ls_rvalid) begin
          push        = !squash_reg && !flush;
          squash_next = 1'b0;
          state_next  = S_FETCH;
        end
      end
      default: state_next = S_FETCH;
    endcase

    count_next = count_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

    // A new request is only allowed when its response is guaranteed a slot.
    if (state_next != S_WAIT)
      state_next = (count_next < FULL_CNT) ? S_FETCH : S_HOLD;

    if (flush) begin
      pc_next    = {redirect_pc[ADDR_W-1:3], 3'b000};
      count_next = '0;
      case (state_reg)
        S_FETCH: begin
          if (ls_gnt) begin
            squash_next = 1'b1;
            state_next  = S_WAIT;
          end else begin
            state_next  = S_FETCH;
          end
        end
        S_WAIT: begin
          squash_next = !ls_rvalid;
          state_next  = ls_rvalid ? S_FETCH : S_WAIT;
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

`ifdef IF_ALIGN_EN
  logic align_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      align_reg <= 1'b0;
    else if (flush)
      align_reg <= redirect_pc[2];
    else if (push)
      align_reg <= 1'b0;
  end

  assign push_even = align_reg ? SPU_NOP : ls_rdata[63:32];
`else
  assign push_even = ls_rdata[63:32];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      pc_reg      <= RESET_PC;
      req_pc_reg  <= RESET_PC;
      squash_reg  <= 1'b0;
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      last_pc_reg <= RESET_PC;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      req_pc_reg  <= req_pc_next;
      squash_reg  <= squash_next;
      count_reg   <= count_next;
      last_pc_reg <= pc_IF;
      rd_ptr_reg  <= flush ? '0 : rd_ptr_reg + PTR_W'(pop);
      wr_ptr_reg  <= flush ? '0 : wr_ptr_reg + PTR_W'(push);
    end
  end

  // Queue storage needs no reset; validity is tracked by count_reg.
  always_ff @(posedge clk) begin
    if (push) begin
      even_mem[wr_ptr_reg] <= push_even;
      odd_mem[wr_ptr_reg]  <= ls_rdata[31:0];
      pc_mem[wr_ptr_reg]   <= req_pc_reg;
    end
  end

  assign ls_req          = (state_reg == S_FETCH) && !reset;
  assign ls_addr         = pc_reg;
  assign fetch_valid     = nonempty;
  assign instruction1_IF = nonempty ? even_mem[rd_ptr_reg] : 32'h0;
  assign instruction2_IF = nonempty ? odd_mem[rd_ptr_reg] : 32'h0;
  assign pc_IF           = nonempty ? pc_mem[rd_ptr_reg] : last_pc_reg;

endmodule
